// File: rtl/parity_pkg.sv
// Shared parity definitions for the parity stream checker.
// Holds the parity mode encodings and the per-lane error function.
package parity_pkg;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Even mode: error when xor != parity.
   // Odd mode: error when xor == parity.
   function automatic logic lane_parity_err(
      input logic lane_xor,
      input logic parity_bit,
      input logic odd
   );
      return lane_xor ^ parity_bit ^ odd;
   endfunction

endpackage

// File: rtl/parity_stream_checker_if.sv
// Valid/ready stream bundle for the parity stream checker.
// slave: checker side; master: producer/consumer side.
interface parity_stream_checker_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4
);
   logic [DATA_WIDTH-1:0] data_in;
   logic [LANES-1:0]      parity_in;
   logic                  valid_in;
   logic                  ready_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic [LANES-1:0]      lane_err;
   logic                  err_out;
   logic                  valid_out;
   logic                  ready_in;

   modport slave (
      input  data_in, parity_in, valid_in, ready_in,
      output ready_out, data_out, lane_err, err_out,
      output valid_out
   );

   modport master (
      output data_in, parity_in, valid_in, ready_in,
      input  ready_out, data_out, lane_err, err_out,
      input  valid_out
   );
endinterface

// File: rtl/parity_lane_check.sv
// Combinational parity check of one lane.
// Ports: lane (LW bits), parity, odd (mode) -> err.
module parity_lane_check
   import parity_pkg::*;
#(
   parameter int LW = 8
) (
   input  logic [LW-1:0] lane,
   input  logic          parity,
   input  logic          odd,
   output logic          err
);

   logic w_xor;

   assign w_xor = ^lane;
   assign err   = lane_parity_err(w_xor, parity, odd);

endmodule

// File: rtl/parity_stream_checker.sv
// Pipelined multi-lane parity checker with error status.
// Ports: clk, rst_n, odd_sel, clear, stream bundle s,
//        err_sticky, first_err, err_count.
module parity_stream_checker
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 odd_sel,
   input  logic                 clear,
   parity_stream_checker_if.slave s,
   output logic                 err_sticky,
   output logic [LANES-1:0]     first_err,
   output logic [CNT_WIDTH-1:0] err_count
);

   localparam int LW = DATA_WIDTH / LANES;

   logic [LANES-1:0]      w_lane_err;
   logic                  w_accept;
   logic                  w_new_err;

   logic [DATA_WIDTH-1:0] r_data;
   logic [LANES-1:0]      r_lane_err;
   logic                  r_err;
   logic                  r_valid;
   logic                  r_sticky;
   logic [LANES-1:0]      r_first;
   logic [CNT_WIDTH-1:0]  r_count;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      parity_lane_check #(.LW(LW)) u_lane (
         .lane   (s.data_in[g*LW +: LW]),
         .parity (s.parity_in[g]),
         .odd    (odd_sel),
         .err    (w_lane_err[g])
      );
   end

   assign s.ready_out = !r_valid || s.ready_in;
   assign w_accept    = s.valid_in && s.ready_out;
   assign w_new_err   = w_accept && (|w_lane_err);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data     <= '0;
         r_lane_err <= '0;
         r_err      <= 1'b0;
         r_valid    <= 1'b0;
      end else if (w_accept) begin
         r_data     <= s.data_in;
         r_lane_err <= w_lane_err;
         r_err      <= |w_lane_err;
         r_valid    <= 1'b1;
      end else if (s.ready_in) begin
         r_valid    <= 1'b0;
      end
   end

   // Clear restarts the status from the current beat,
   // so an error arriving with clear is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 1'b0;
         r_first  <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_sticky <= w_new_err;
         r_first  <= w_new_err ? w_lane_err : '0;
         r_count  <= w_new_err ? CNT_WIDTH'(1) : '0;
      end else if (w_new_err) begin
         r_sticky <= 1'b1;
         if (!r_sticky)
            r_first <= w_lane_err;
         if (r_count != '1)
            r_count <= r_count + CNT_WIDTH'(1);
      end
   end

   assign s.data_out  = r_data;
   assign s.lane_err  = r_lane_err;
   assign s.err_out   = r_err;
   assign s.valid_out = r_valid;
   assign err_sticky  = r_sticky;
   assign first_err   = r_first;
   assign err_count   = r_count;

endmodule
